// File: rtl/booth_pkg.sv
// Shared types and width helpers for the radix-2 Booth multiplier family.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB
  } booth_op_t;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 32;

  // Operands carry one extra bit so signed and unsigned share one datapath.
  function automatic int ext_w(input int w);
    return w + 1;
  endfunction

  // The accumulator carries a guard bit so A +/- M cannot overflow.
  function automatic int acc_w(input int w);
    return w + 2;
  endfunction

  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_radix2_step.sv
// One combinational radix-2 Booth iteration: add/sub M, then arithmetic shift {A,Q,q_1}.
module booth_radix2_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [acc_w(WIDTH)-1:0] a_i,
  input  logic [ext_w(WIDTH)-1:0] q_i,
  input  logic                    q_1_i,
  input  logic [ext_w(WIDTH)-1:0] m_i,
  output logic [acc_w(WIDTH)-1:0] a_o,
  output logic [ext_w(WIDTH)-1:0] q_o,
  output logic                    q_1_o
);

  localparam int EW = ext_w(WIDTH);
  localparam int AW = acc_w(WIDTH);

  logic [AW-1:0] m_ext;
  logic [AW-1:0] sum;
  booth_op_t     op;

  always_comb begin
    m_ext = {m_i[EW-1], m_i};
    op    = booth_decode(q_i[0], q_1_i);
    case (op)
      OP_ADD:  sum = a_i + m_ext;
      OP_SUB:  sum = a_i - m_ext;
      default: sum = a_i;
    endcase
    a_o   = {sum[AW-1], sum[AW-1:1]};
    q_o   = {sum[0], q_i[EW-1:1]};
    q_1_o = q_i[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier, one step per clock, signed/unsigned per operation.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | running Booth iterations, counter counts down to 1
// DONE  | product held on out_p until out_ready
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int EW = ext_w(WIDTH);
  localparam int AW = acc_w(WIDTH);

  state_t              state_q, state_d;
  logic [AW-1:0]       a_q, a_d;
  logic [EW-1:0]       q_q, q_d;
  logic                q1_q, q1_d;
  logic [EW-1:0]       m_q, m_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sgn_q, sgn_d;
  logic [2*WIDTH-1:0]  p_q, p_d;

  logic [AW-1:0]       step_a;
  logic [EW-1:0]       step_q;
  logic                step_q1;
  logic [2*WIDTH-1:0]  prod_s;
  logic [2*WIDTH-1:0]  prod_u;
  logic [1:0]          unused_a_top;

  booth_radix2_step #(.WIDTH(WIDTH)) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .q_1_i (q1_q),
    .m_i   (m_q),
    .a_o   (step_a),
    .q_o   (step_q),
    .q_1_o (step_q1)
  );

  // Signed mode runs one fewer shift, so its product sits one bit higher in {A,Q}.
  assign prod_s       = {step_a[WIDTH-1:0], step_q[EW-1:1]};
  assign prod_u       = {step_a[WIDTH-2:0], step_q};
  assign unused_a_top = step_a[AW-1:AW-2];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = '0;
          q1_d    = 1'b0;
          q_d     = in_signed ? {in_q[WIDTH-1], in_q} : {1'b0, in_q};
          m_d     = in_signed ? {in_m[WIDTH-1], in_m} : {1'b0, in_m};
          cnt_d   = in_signed ? CNT_W'(WIDTH) : CNT_W'(WIDTH + 1);
          sgn_d   = in_signed;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d   = step_a;
        q_d   = step_q;
        q1_d  = step_q1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          p_d     = sgn_q ? prod_s : prod_u;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      p_q     <= p_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_p     = p_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomised checks of booth_mult_seq at WIDTH 8, 13 and 16.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_signed;
  logic        out_ready;
  logic [15:0] m_in, q_in;
  logic        iv8, iv13, iv16;
  logic        ir8, ir13, ir16;
  logic        ov8, ov13, ov16;
  logic        bz8, bz13, bz16;
  logic [15:0] p8;
  logic [25:0] p13;
  logic [31:0] p16;

  int total = 0;
  int bad   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_signed(in_signed),
    .in_m(m_in[7:0]), .in_q(q_in[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .out_p(p8), .busy(bz8));

  booth_mult_seq #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .in_valid(iv13), .in_ready(ir13), .in_signed(in_signed),
    .in_m(m_in[12:0]), .in_q(q_in[12:0]), .out_valid(ov13), .out_ready(out_ready),
    .out_p(p13), .busy(bz13));

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_signed(in_signed),
    .in_m(m_in), .in_q(q_in), .out_valid(ov16), .out_ready(out_ready),
    .out_p(p16), .busy(bz16));

  function automatic logic get_ir(input int w);
    case (w)
      8:       return ir8;
      13:      return ir13;
      default: return ir16;
    endcase
  endfunction

  function automatic logic get_ov(input int w);
    case (w)
      8:       return ov8;
      13:      return ov13;
      default: return ov16;
    endcase
  endfunction

  function automatic logic get_bz(input int w);
    case (w)
      8:       return bz8;
      13:      return bz13;
      default: return bz16;
    endcase
  endfunction

  function automatic logic [31:0] get_p(input int w);
    case (w)
      8:       return {16'd0, p8};
      13:      return {6'd0, p13};
      default: return p16;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input int w, input logic sgn,
                                          input logic [15:0] m, input logic [15:0] q);
    longint mm, qq, pr;
    mm = longint'(m);
    qq = longint'(q);
    if (sgn) begin
      if (m[w-1]) mm = mm - (longint'(1) << w);
      if (q[w-1]) qq = qq - (longint'(1) << w);
    end
    pr = mm * qq;
    return 32'(pr & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_iv(input int w, input logic v);
    iv8  = v && (w == 8);
    iv13 = v && (w == 13);
    iv16 = v && (w == 16);
  endtask

  // Called at a negedge; returns at the negedge after the DUT is back in IDLE.
  task automatic do_op(input int w, input logic sgn, input logic [15:0] m,
                       input logic [15:0] q, input logic [31:0] exp_p,
                       input int exp_lat, input int hold, input string tag);
    int          lat;
    logic        busy_ok;
    logic        stable;
    logic [31:0] p0;
    chk({tag, "_ready_idle"}, 64'(get_ir(w)), 64'd1);
    if (get_ir(w)) acc_cnt++;
    set_iv(w, 1'b1);
    in_signed = sgn;
    m_in = m;
    q_in = q;
    @(negedge clk);
    set_iv(w, 1'b0);
    m_in = 16'($urandom);
    q_in = 16'($urandom);
    in_signed = ~sgn;
    lat = 0;
    busy_ok = 1'b1;
    while (!get_ov(w) && lat < 64) begin
      if (get_ir(w) || !get_bz(w)) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (get_ov(w)) done_cnt++;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_product"}, 64'(get_p(w)), 64'(exp_p));
    chk({tag, "_busy_no_ready"}, 64'(busy_ok), 64'd1);
    p0 = get_p(w);
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (get_p(w) !== p0 || !get_ov(w) || get_ir(w)) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {62'd0, get_ir(w), get_ov(w)}, 64'b10);
  endtask

  task automatic rand_ops(input int w, input logic sgn, input int n);
    logic [15:0] m, q, mask;
    mask = 16'((32'd1 << w) - 1);
    for (int i = 0; i < n; i++) begin
      m = 16'($urandom) & mask;
      q = 16'($urandom) & mask;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(w, sgn, m, q, ref_mul(w, sgn, m, q), sgn ? w : w + 1,
            int'($urandom_range(0, 3)), $sformatf("rnd_w%0d_s%0d", w, sgn));
    end
  endtask

  initial begin
    rst = 1'b1;
    in_signed = 1'b0;
    out_ready = 1'b0;
    m_in = '0;
    q_in = '0;
    set_iv(0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {61'd0, ir8, ir13, ir16}, 64'b111);
    chk("rst_out_valid", {61'd0, ov8, ov13, ov16}, 64'b000);
    chk("rst_busy", {61'd0, bz8, bz13, bz16}, 64'b000);
    chk("rst_out_p", {16'd0, p8 | p16[15:0], 6'd0, p13}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(8, 1'b1, 16'h0007, 16'h00FD, 32'h0000FFEB, 8, 0, "s8_7x-3");
    do_op(8, 1'b1, 16'h0080, 16'h0080, 32'h00004000, 8, 0, "s8_min_sq");
    do_op(8, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, 9, 0, "u8_max_sq");
    do_op(16, 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, 16, 0, "s16_min_x_max");
    do_op(16, 1'b0, 16'hFFFF, 16'h0002, 32'h0001FFFE, 17, 0, "u16_max_x2");

    // Backpressure, then the next pair offered on the first IDLE cycle.
    do_op(8, 1'b0, 16'h0003, 16'h0004, 32'h0000000C, 9, 20, "bp_3x4");
    do_op(8, 1'b1, 16'h0009, 16'h00FE, 32'h0000FFEE, 8, 0, "bp_next_9x-2");

    // Reset during the 4th BUSY cycle discards the operation.
    set_iv(8, 1'b1);
    in_signed = 1'b1;
    m_in = 16'd100;
    q_in = 16'd100;
    @(negedge clk);
    set_iv(8, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_rst_busy_before", 64'(bz8), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", {60'd0, ir8, ov8, bz8, 1'b0}, 64'b1000);
    chk("mid_rst_out_p", 64'(p8), 64'd0);
    repeat (12) @(negedge clk);
    chk("mid_rst_no_output", {62'd0, ov8, ir8}, 64'b01);
    do_op(8, 1'b1, 16'h0005, 16'h0006, 32'h0000001E, 8, 0, "after_rst_5x6");

    acc_cnt = 0;
    done_cnt = 0;
    rand_ops(8, 1'b1, 100);
    rand_ops(8, 1'b0, 100);
    rand_ops(13, 1'b1, 100);
    rand_ops(13, 1'b0, 100);
    chk("rnd_op_count", 64'(done_cnt), 64'(acc_cnt));
    chk("rnd_acc_count", 64'(acc_cnt), 64'd400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
